pipelined_adder: RTL and testbench

- Parametrised successor to the single-cycle adder.
- Adds or subtracts two WIDTH-bit operands through a LATENCY-stage register pipeline.
- Uses a valid/ready handshake on both sides with full backpressure.
- Reports carry/borrow, signed overflow and a running count of delivered results.
- Sits between a stimulus/producer stage and a consumer that may stall.

---
 rtl/pipelined_adder_if.sv | 29 ++
 rtl/pipelined_adder.sv | 84 ++++++++
 tb/tb_pipelined_adder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ======================================================================
// pipelined_adder_if : operand/result valid-ready bundle for pipelined_adder
// Revision: 1.0
// ======================================================================
interface pipelined_adder_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   c;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, sub, in_valid, out_ready,
    input  in_ready, c, ovf, out_valid
  );

  modport slave (
    input  a, b, sub, in_valid, out_ready,
    output in_ready, c, ovf, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ======================================================================
// pipelined_adder : WIDTH-bit add/sub through a LATENCY-deep pipeline
//                   that stalls as one unit under output backpressure
// Revision: 1.0
// ======================================================================
module pipelined_adder #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipelined_adder_if.slave bus,
  output logic [CNT_W-1:0] res_cnt
);
  localparam int DW  = WIDTH + 2;
  localparam int MSB = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                         stall;
  logic                         accept;
  logic                         deliver;
  logic [WIDTH:0]               sum_d;
  logic                         ovf_d;
  logic [CNT_W-1:0]             cnt_d;
  logic [LATENCY-1:0]           vld_q;
  logic [LATENCY-1:0][DW-1:0]   dat_q;
  logic [CNT_W-1:0]             cnt_q;

  assign stall   = vld_q[LATENCY-1] && !bus.out_ready;
  assign accept  = bus.in_valid && !stall;
  assign deliver = vld_q[LATENCY-1] && bus.out_ready;

  // The extra top bit of the WIDTH+1 difference is exactly the unsigned borrow.
  always_comb begin
    sum_d = '0;
    ovf_d = 1'b0;
    if (bus.sub) begin
      sum_d = {1'b0, bus.a} - {1'b0, bus.b};
      ovf_d = (bus.a[MSB] != bus.b[MSB]) && (sum_d[MSB] != bus.a[MSB]);
    end else begin
      sum_d = {1'b0, bus.a} + {1'b0, bus.b};
      ovf_d = (bus.a[MSB] == bus.b[MSB]) && (sum_d[MSB] != bus.a[MSB]);
    end
  end

  // Data only moves behind a valid token so the output keeps its last result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (!stall) begin
      vld_q[0] <= accept;
      if (accept) begin
        dat_q[0] <= {ovf_d, sum_d};
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign cnt_d = cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (deliver) begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = vld_q[LATENCY-1];
  assign bus.c         = dat_q[LATENCY-1][WIDTH:0];
  assign bus.ovf       = dat_q[LATENCY-1][WIDTH+1];
  assign res_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ======================================================================
// tb_pipelined_adder : randomized + directed bench with a behavioural
//                      scoreboard; second instance uses a 4-bit counter
// Revision: 1.0
// ======================================================================
module tb_pipelined_adder;
  localparam int WIDTH   = 8;
  localparam int LATENCY = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] res_cnt;
  logic [3:0]  res_cnt4;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus  ();
  pipelined_adder_if #(.WIDTH(WIDTH)) bus4 ();

  assign bus4.a         = bus.a;
  assign bus4.b         = bus.b;
  assign bus4.sub       = bus.sub;
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.out_ready = bus.out_ready;

  pipelined_adder #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (bus),
    .res_cnt (res_cnt)
  );

  pipelined_adder #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(4)) dut4 (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (bus4),
    .res_cnt (res_cnt4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic from plain integer maths; returns {ovf, c}.
  function automatic logic [WIDTH+1:0] ref_op(input longint x, input longint y, input bit s);
    longint full, half, sx, sy, r, sr;
    bit     ov;
    full = longint'(1) << WIDTH;
    half = longint'(1) << (WIDTH - 1);
    sx = (x >= half) ? x - full : x;
    sy = (y >= half) ? y - full : y;
    if (s) begin
      r  = x - y;
      if (r < 0) r = r + 2 * full;
      sr = sx - sy;
    end else begin
      r  = x + y;
      sr = sx + sy;
    end
    ov = (sr >= half) || (sr < -half);
    return {ov, r[WIDTH:0]};
  endfunction

  // Model state: stage occupancy, in-order expected results, last shown result.
  bit                 mv [LATENCY];
  logic [WIDTH+1:0]   exp_q [$];
  logic [WIDTH:0]     last_c;
  logic               last_ovf;
  int unsigned        delivered;
  int unsigned        accepted;
  bit                 acc_flag;

  task automatic clear_model();
    for (int k = 0; k < LATENCY; k++) mv[k] = 1'b0;
    exp_q.delete();
    last_c    = '0;
    last_ovf  = 1'b0;
    delivered = 0;
    accepted  = 0;
    acc_flag  = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step();
    bit stall, acc, dlv;
    logic [WIDTH+1:0] r;
    @(negedge clk);
    stall = mv[LATENCY-1] && !bus.out_ready;
    check_val("in_ready",  64'(bus.in_ready),  64'(!stall));
    check_val("out_valid", 64'(bus.out_valid), 64'(mv[LATENCY-1]));
    check_val("out_valid4",64'(bus4.out_valid),64'(mv[LATENCY-1]));
    if (mv[LATENCY-1]) begin
      if (exp_q.size() == 0) begin
        check_val("scoreboard_empty", 64'(exp_q.size()), 64'(1));
      end else begin
        last_c   = exp_q[0][WIDTH:0];
        last_ovf = exp_q[0][WIDTH+1];
      end
    end
    check_val("c",        64'(bus.c),    64'(last_c));
    check_val("ovf",      64'(bus.ovf),  64'(last_ovf));
    check_val("c4",       64'(bus4.c),   64'(last_c));
    check_val("res_cnt",  64'(res_cnt),  64'(delivered % 65536));
    check_val("res_cnt4", 64'(res_cnt4), 64'(delivered % 16));
    acc = bus.in_valid && !stall;
    dlv = mv[LATENCY-1] && bus.out_ready;
    r   = ref_op(longint'(bus.a), longint'(bus.b), bus.sub);
    @(posedge clk);
    if (dlv) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      delivered++;
    end
    if (acc) begin
      exp_q.push_back(r);
      accepted++;
    end
    if (!stall) begin
      for (int k = LATENCY - 1; k > 0; k--) mv[k] = mv[k-1];
      mv[0] = acc;
    end
    acc_flag = acc;
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_val("rst_c",         64'(bus.c),         64'(0));
    check_val("rst_res_cnt",   64'(res_cnt),       64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
  endtask

  // Single directed operation with a literal expected result at exact latency.
  task automatic direct_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic s, input logic [8:0] exp_c, input logic exp_ovf);
    int unsigned cnt0;
    cnt0 = delivered;
    bus.a = x; bus.b = y; bus.sub = s;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    check_val({tag, "_acc"}, 64'(acc_flag), 64'(1));
    bus.in_valid = 1'b0;
    repeat (LATENCY - 1) step();
    check_val({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    check_val({tag, "_c"},     64'(bus.c),         64'(exp_c));
    check_val({tag, "_ovf"},   64'(bus.ovf),       64'(exp_ovf));
    step();
    check_val({tag, "_cnt"}, 64'(res_cnt), 64'(cnt0 + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v;
    int          budget;

    clear_model();
    do_reset();
    step();
    check_val("reset_res_cnt", 64'(res_cnt), 64'(0));

    // Arithmetic corners
    direct_op("ff_plus_1",  8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    direct_op("7f_plus_1",  8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    direct_op("5_minus_7",  8'h05, 8'h07, 1'b1, 9'h1FE, 1'b0);
    direct_op("80_minus_1", 8'h80, 8'h01, 1'b1, 9'h07F, 1'b1);

    // Backpressure: values 1..4, consumer stalled then released
    do_reset();
    v = 1;
    bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      bus.a = 8'(v);
      step();
      if (acc_flag) v++;
    end
    check_val("bp_in_ready", 64'(bus.in_ready),  64'(0));
    check_val("bp_valid",    64'(bus.out_valid), 64'(1));
    check_val("bp_hold_c",   64'(bus.c),         64'(9'h001));
    bus.out_ready = 1'b1;
    budget = 0;
    while (delivered < 4 && budget < 20) begin
      if (v <= 4) begin
        bus.a = 8'(v);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (acc_flag) v++;
      budget++;
    end
    step();
    check_val("bp_res_cnt", 64'(res_cnt), 64'(4));

    // Counter wrap on the 4-bit instance
    do_reset();
    bus.out_ready = 1'b1;
    budget = 0;
    while (delivered < 17 && budget < 40) begin
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.sub = 1'($urandom);
      bus.in_valid = (accepted < 17);
      step();
      budget++;
    end
    bus.in_valid = 1'b0;
    check_val("wrap_res_cnt4", 64'(res_cnt4), 64'(1));
    check_val("wrap_res_cnt",  64'(res_cnt),  64'(17));

    // Random streaming with bubbles and backpressure
    do_reset();
    budget = 0;
    while (accepted < 1000 && budget < 10000) begin
      if (!bus.in_valid || acc_flag) begin
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.sub      = 1'($urandom);
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
      budget++;
    end
    check_val("rand_accepted", 64'(accepted), 64'(1000));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    budget = 0;
    while (delivered < accepted && budget < 20) begin
      step();
      budget++;
    end
    step();
    check_val("rand_res_cnt", 64'(res_cnt), 64'(accepted));

    // Reset mid-flight: fill the pipeline under stall, then reset between edges
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) begin
      bus.a = 8'($urandom); bus.b = 8'($urandom);
      step();
    end
    check_val("mid_valid_before", 64'(bus.out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_out_valid", 64'(bus.out_valid), 64'(0));
    check_val("mid_res_cnt",   64'(res_cnt),       64'(0));
    check_val("mid_in_ready",  64'(bus.in_ready),  64'(1));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
